spi_reg_bridge: RTL and testbench

//  Downstream consumer of the SPI slave byte interface. Brings rx_data/data_valid/cs from the sclk domain

---
 rtl/spi_reg_bridge.sv | 139 +++++++++++++
 tb/tb_spi_reg_bridge.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// SPI slave byte-stream to register-file bridge: synchronises valid/cs into clk,
// decodes {rw, addr} command frames, and returns read data to the slave's TX path.
module spi_reg_bridge #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                spi_rx_data,
  input  logic                      spi_data_valid,
  input  logic                      spi_cs,
  output logic [7:0]                spi_tx_data,
  output logic                      spi_tx_start,
  output logic [8*(1<<ADDR_W)-1:0]  reg_q,
  output logic                      wr_strobe,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [7:0]                wr_data,
  output logic [7:0]                err_cnt
);

  localparam int unsigned NREG = 1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, DISCARD} state_t;

  state_t                  state, state_n;
  logic [SYNC_STAGES-1:0]  valid_sync, cs_sync;
  logic                    valid_prev, cs_prev;
  logic                    byte_stb, cs_fall, cs_rise;
  logic [ADDR_W-1:0]       ptr, ptr_n, tx_idx;
  logic                    do_wr, do_tx, err_inc;
  logic [7:0]              regs [NREG];
  logic                    cmd_rw, addr_ok;
  logic [6:0]              cmd_addr;
  logic [ADDR_W-1:0]       cmd_ptr;

  // Synchronisers; cs chain idles deasserted so reset never fakes a cs edge into CMD mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sync <= '0;
      cs_sync    <= '1;
      valid_prev <= 1'b0;
      cs_prev    <= 1'b1;
    end else begin
      valid_sync <= {valid_sync[SYNC_STAGES-2:0], spi_data_valid};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      valid_prev <= valid_sync[SYNC_STAGES-1];
      cs_prev    <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign byte_stb = valid_sync[SYNC_STAGES-1] & ~valid_prev;
  assign cs_fall  = ~cs_sync[SYNC_STAGES-1] & cs_prev;
  assign cs_rise  = cs_sync[SYNC_STAGES-1] & ~cs_prev;

  assign cmd_rw   = spi_rx_data[7];
  assign cmd_addr = spi_rx_data[6:0];
  assign addr_ok  = (cmd_addr >> ADDR_W) == 7'd0;
  assign cmd_ptr  = cmd_addr[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and per-cycle action decode.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    tx_idx  = ptr;
    do_wr   = 1'b0;
    do_tx   = 1'b0;
    err_inc = 1'b0;
    if (state != IDLE && cs_fall) begin
      state_n = CMD;
    end else begin
      unique case (state)
        IDLE: if (cs_fall) state_n = CMD;
        CMD: if (byte_stb) begin
          if (!addr_ok) begin
            err_inc = 1'b1;
            state_n = DISCARD;
          end else if (cmd_rw) begin
            ptr_n   = cmd_ptr;
            state_n = WRITE;
          end else begin
            do_tx   = 1'b1;
            tx_idx  = cmd_ptr;
            ptr_n   = cmd_ptr + ADDR_W'(1);
            state_n = READ;
          end
        end
        WRITE: if (byte_stb) begin
          do_wr = 1'b1;
          ptr_n = ptr + ADDR_W'(1);
        end
        READ: if (byte_stb) begin
          do_tx = 1'b1;
          ptr_n = ptr + ADDR_W'(1);
        end
        DISCARD: ;
        default: state_n = IDLE;
      endcase
      // A byte that lands with cs release still writes/counts, but nothing is sent back.
      if (cs_rise) begin
        state_n = IDLE;
        do_tx   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= 8'h00;
      ptr          <= '0;
      spi_tx_data  <= 8'h00;
      spi_tx_start <= 1'b0;
      wr_strobe    <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 8'h00;
      err_cnt      <= 8'h00;
    end else begin
      ptr          <= ptr_n;
      spi_tx_start <= do_tx;
      wr_strobe    <= do_wr;
      if (do_tx) spi_tx_data <= regs[tx_idx];
      if (do_wr) begin
        regs[ptr] <= spi_rx_data;
        wr_addr   <= ptr;
        wr_data   <= spi_rx_data;
      end
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  for (genvar g = 0; g < int'(NREG); g++) begin : g_regq
    assign reg_q[8*g +: 8] = regs[g];
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: stimulus pushes expected writes/tx bytes,
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_spi_reg_bridge;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREG   = 1 << ADDR_W;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [7:0]           spi_rx_data;
  logic                 spi_data_valid;
  logic                 spi_cs;
  logic [7:0]           spi_tx_data;
  logic                 spi_tx_start;
  logic [8*NREG-1:0]    reg_q;
  logic                 wr_strobe;
  logic [ADDR_W-1:0]    wr_addr;
  logic [7:0]           wr_data;
  logic [7:0]           err_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [11:0] wrq[$];
  logic [7:0]  txq[$];
  logic [7:0]  mdl [NREG];

  spi_reg_bridge #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi_rx_data(spi_rx_data), .spi_data_valid(spi_data_valid),
    .spi_cs(spi_cs), .spi_tx_data(spi_tx_data), .spi_tx_start(spi_tx_start), .reg_q(reg_q),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_regs(input string name);
    logic [8*NREG-1:0] flat;
    for (int i = 0; i < int'(NREG); i++) flat[8*i +: 8] = mdl[i];
    chk(name, reg_q, flat);
  endtask

  task automatic exp_wr(input logic [3:0] a, input logic [7:0] d);
    mdl[a] = d;
    wrq.push_back({a, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rise_cs);
    tick();
    spi_rx_data    = b;
    spi_data_valid = 1'b1;
    if (rise_cs) spi_cs = 1'b1;
    repeat (6) tick();
    spi_data_valid = 1'b0;
    repeat (6) tick();
  endtask

  task automatic cs_low();
    tick();
    spi_cs = 1'b0;
    repeat (5) tick();
  endtask

  task automatic cs_high();
    spi_cs = 1'b1;
    repeat (5) tick();
  endtask

  // Monitor: every strobe must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_strobe) begin
        if (wrq.size() == 0) chk("wr_unexpected", wr_strobe, 1'b0);
        else begin
          logic [11:0] e;
          e = wrq.pop_front();
          chk("wr_addr", wr_addr, e[11:8]);
          chk("wr_data", wr_data, e[7:0]);
        end
      end
      if (spi_tx_start) begin
        if (txq.size() == 0) chk("tx_unexpected", spi_tx_start, 1'b0);
        else chk("tx_data", spi_tx_data, txq.pop_front());
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_regq"},   reg_q, '0);
    chk({tag, "_err"},    err_cnt, 8'h00);
    chk({tag, "_txd"},    spi_tx_data, 8'h00);
    chk({tag, "_txs"},    spi_tx_start, 1'b0);
    chk({tag, "_wrs"},    wr_strobe, 1'b0);
    chk({tag, "_wra"},    wr_addr, 4'h0);
    chk({tag, "_wrd"},    wr_data, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < int'(NREG); i++) mdl[i] = 8'h00;
    rst_n = 1'b0; spi_cs = 1'b1; spi_data_valid = 1'b0; spi_rx_data = 8'h00;
    repeat (3) tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (3) tick();

    // Single write
    cs_low();
    send_byte(8'h83, 0);
    exp_wr(4'd3, 8'hA5); send_byte(8'hA5, 0);
    cs_high();
    chk_regs("t1_regs");
    chk("t1_err", err_cnt, 8'h00);

    // Burst with address wrap
    cs_low();
    send_byte(8'h8E, 0);
    exp_wr(4'd14, 8'h11); send_byte(8'h11, 0);
    exp_wr(4'd15, 8'h22); send_byte(8'h22, 0);
    exp_wr(4'd0,  8'h33); send_byte(8'h33, 0);
    cs_high();
    chk_regs("t2_regs");

    // Preload then read back reg5, reg6, reg7
    cs_low();
    send_byte(8'h85, 0);
    exp_wr(4'd5, 8'h5A); send_byte(8'h5A, 0);
    exp_wr(4'd6, 8'h6B); send_byte(8'h6B, 0);
    cs_high();
    cs_low();
    txq.push_back(8'h5A); send_byte(8'h05, 0);
    txq.push_back(8'h6B); send_byte(8'hC3, 0);
    txq.push_back(8'h00); send_byte(8'h3C, 0);
    cs_high();
    chk_regs("t3_regs");

    // Out-of-range command is discarded and counted
    cs_low();
    send_byte(8'h90, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    cs_high();
    chk_regs("t4_regs");
    chk("t4_err1", err_cnt, 8'h01);
    for (int n = 0; n < 253; n++) begin
      cs_low(); send_byte(8'hF0, 0); cs_high();
    end
    chk("t4_err254", err_cnt, 8'hFE);
    for (int n = 0; n < 46; n++) begin
      cs_low(); send_byte(8'h90, 0); cs_high();
    end
    chk("t4_err_sat", err_cnt, 8'hFF);

    // Last byte and cs release coincide: write lands, no tx for a read
    cs_low();
    send_byte(8'h82, 0);
    exp_wr(4'd2, 8'h77); send_byte(8'h77, 1);
    repeat (5) tick();
    chk_regs("t5_regs");
    cs_low();
    send_byte(8'h05, 1);
    repeat (5) tick();
    cs_low();
    send_byte(8'h84, 0);
    exp_wr(4'd4, 8'h99); send_byte(8'h99, 0);
    cs_high();
    chk_regs("t5_next");
    chk("t5_err", err_cnt, 8'hFF);

    // Async reset mid-burst, then bytes with cs high are ignored
    cs_low();
    send_byte(8'h88, 0);
    exp_wr(4'd8, 8'h42); send_byte(8'h42, 0);
    tick();
    spi_rx_data = 8'h43; spi_data_valid = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < int'(NREG); i++) mdl[i] = 8'h00;
    chk_reset_outputs("t6");
    spi_cs = 1'b1; spi_data_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    send_byte(8'h81, 0);
    send_byte(8'hEE, 0);
    chk_regs("t6_ignored");
    cs_low();
    send_byte(8'h81, 0);
    exp_wr(4'd1, 8'h55); send_byte(8'h55, 0);
    cs_high();
    chk_regs("t6_regs");
    chk("t6_err", err_cnt, 8'h00);

    repeat (5) tick();
    chk("wrq_empty", 32'(wrq.size()), 32'd0);
    chk("txq_empty", 32'(txq.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
